// File: rtl/psum_triple_issuer_if.sv
// Bus bundle for the partial-sum triple issuer.
// Groups the upstream triple handshake and the three downstream lane handshakes.
//   in_data/in_valid/in_ready         : packed triple in, {psum2, psum1, psum0}
//   outN_data/outN_valid/outN_ready   : lane N toward the psum adder, N = 0..2
// Modport master is the issuer's view: it takes the upstream triple and drives the lanes.
// Modport slave is the surrounding environment's view: the collector side plus the adder side.
interface psum_triple_issuer_if #(
    parameter int unsigned DWIDTH = 8
) ();
    logic [3*DWIDTH-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DWIDTH-1:0]   out0_data;
    logic [DWIDTH-1:0]   out1_data;
    logic [DWIDTH-1:0]   out2_data;
    logic                out0_valid;
    logic                out1_valid;
    logic                out2_valid;
    logic                out0_ready;
    logic                out1_ready;
    logic                out2_ready;

    modport master (
        input  in_data, in_valid, out0_ready, out1_ready, out2_ready,
        output in_ready, out0_data, out1_data, out2_data,
               out0_valid, out1_valid, out2_valid
    );

    modport slave (
        output in_data, in_valid, out0_ready, out1_ready, out2_ready,
        input  in_ready, out0_data, out1_data, out2_data,
               out0_valid, out1_valid, out2_valid
    );
endinterface

// File: rtl/psum_triple_issuer.sv
// Partial-sum triple issuer: buffers packed triples in a small FIFO and issues
// each one on three independent valid/ready lanes. The next triple is loaded
// only once all three lanes of the current one have handshaken (fork/join).
// Ports:
//   clk          : system clock, rising edge
//   reset        : synchronous active-high reset
//   bus          : psum_triple_issuer_if.master (input triple + three output lanes)
//   triple_count : number of fully issued triples, wraps modulo 2^COUNT_W
//   busy         : FIFO non-empty or any lane still pending
module psum_triple_issuer #(
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    psum_triple_issuer_if.master    bus,
    output logic [COUNT_W-1:0]      triple_count,
    output logic                    busy
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = 3 * DWIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [2:0]               pend;
    logic [2:0]               pend_nxt;
    logic [2:0]               ready_vec;
    logic [2:0]               pend_left;
    logic                     push;
    logic                     pop;
    logic                     complete;
    logic                     full;

    logic [TW-1:0]            mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              fifo_count;
    logic [2:0][DWIDTH-1:0]   lane_data;

    // Acceptance depends only on registered occupancy; a full FIFO never takes a
    // triple even when a pop happens in the same cycle.
    assign full         = (fifo_count == (AW+1)'(DEPTH));
    assign bus.in_ready = !reset && !full;
    assign push         = bus.in_valid && bus.in_ready;

    assign ready_vec = {bus.out2_ready, bus.out1_ready, bus.out0_ready};
    // Lanes still outstanding after this edge's handshakes.
    assign pend_left = pend & ~ready_vec;

    assign bus.out0_valid = pend[0];
    assign bus.out1_valid = pend[1];
    assign bus.out2_valid = pend[2];
    assign bus.out0_data  = lane_data[0];
    assign bus.out1_data  = lane_data[1];
    assign bus.out2_data  = lane_data[2];

    assign busy = (fifo_count != '0) || (pend != 3'b000);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pend  <= 3'b000;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // Next state: load from IDLE, join the lanes in ISSUE and reload without a bubble.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        pop       = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    pend_nxt  = 3'b111;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                pend_nxt = pend_left;
                if (pend_left == 3'b000) begin
                    complete = 1'b1;
                    if (fifo_count != '0) begin
                        pop      = 1'b1;
                        pend_nxt = 3'b111;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                pend_nxt  = 3'b000;
            end
        endcase
    end

    // FIFO storage; contents need no reset since pointers and count gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // FIFO pointers, occupancy, lane registers and the issued-triple counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            lane_data    <= '0;
            triple_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                lane_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (complete) begin
                triple_count <= triple_count + COUNT_W'(1);
            end
        end
    end
endmodule
